// File: rtl/rv32i_types.sv
// rv32i_types: shared word, fetch FSM state and fetch queue entry types.
// Imported by the fetch unit, its queue and the IF bus interface users.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_DROP
    } fetch_state_t;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    localparam int FETCH_STEP = 4;

endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction memory read/resp port plus IF->ID handshake.
// master = fetch unit side, slave = memory / decode side.
interface if_fetch_unit_if #(
    parameter int XLEN = 32
);

    logic            imem_read_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_resp_i;
    logic [31:0]     imem_rdata_i;
    logic            ID_ready_i;
    logic            IF_valid_o;
    logic [XLEN-1:0] IF_pc_out_o;
    logic [31:0]     IF_instr_out_o;

    modport master (
        output imem_read_o,
        output imem_addr_o,
        input  imem_resp_i,
        input  imem_rdata_i,
        input  ID_ready_i,
        output IF_valid_o,
        output IF_pc_out_o,
        output IF_instr_out_o
    );

    modport slave (
        input  imem_read_o,
        input  imem_addr_o,
        output imem_resp_i,
        output imem_rdata_i,
        output ID_ready_i,
        input  IF_valid_o,
        input  IF_pc_out_o,
        input  IF_instr_out_o
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of {pc, instr} with flush.
// Flush dominates enqueue and dequeue; head reads zero when empty.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       enq_i,
    input  fetch_entry_t               enq_data_i,
    input  logic                       deq_i,
    output fetch_entry_t               head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  rd_q;
    logic [AW-1:0]  wr_q;
    logic [CW-1:0]  cnt_q;
    logic           do_enq;
    logic           do_deq;

    assign do_enq = enq_i && !flush_i;
    assign do_deq = deq_i && !flush_i && (cnt_q != '0);

    // Entry storage: written at the tail on every accepted enqueue.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_q[wr_q] <= enq_data_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_enq) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_deq) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({do_enq, do_deq})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/pc_register.sv
// pc_register: loadable program counter with synchronous active-low reset.
// Holds its value unless load_i is high.
module pc_register #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    logic [W-1:0] pc_q;

    // PC register: reset vector on reset, new value on load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RST_VAL;
        end else if (load_i) begin
            pc_q <= in_i;
        end
    end

    assign out_o = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, issues imem reads and queues fetched words.
// EX redirects flush the queue and squash any stale in-flight response.
module if_fetch_unit
    import rv32i_types::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h6000_0000)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    if_fetch_unit_if.master            bus,
    output logic [$clog2(DEPTH+1)-1:0] fq_count_o
);

    localparam int CW  = $clog2(DEPTH+1);
    localparam int CW1 = CW + 1;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pc_ld;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] tgt;
    logic            enq;
    logic            deq;
    logic            flush;
    logic            fq_valid;
    logic [CW-1:0]   cnt;
    logic [CW:0]     cnt_next;
    logic            space_next;
    fetch_entry_t    enq_data;
    fetch_entry_t    head;

    assign pc_inc = fetch_pc_q + XLEN'(FETCH_STEP);
    assign tgt    = redirect_pc_i & ~XLEN'(3);

    pc_register #(
        .W       (XLEN),
        .RST_VAL (RESET_VEC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_ld),
        .in_i   (pc_d),
        .out_o  (fetch_pc_q)
    );

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fq (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .enq_i      (enq),
        .enq_data_i (enq_data),
        .deq_i      (deq),
        .head_o     (head),
        .valid_o    (fq_valid),
        .count_o    (cnt)
    );

    // Queue control and post-cycle occupancy used by the issue rule.
    always_comb begin
        flush          = redirect_i;
        deq            = fq_valid && bus.ID_ready_i;
        enq            = (state_q == F_WAIT) && bus.imem_resp_i && !redirect_i;
        enq_data.pc    = rv32i_word'(fetch_pc_q);
        enq_data.instr = bus.imem_rdata_i;
        if (flush) begin
            cnt_next = '0;
        end else begin
            cnt_next = {1'b0, cnt} + CW1'(enq) - CW1'(deq);
        end
        space_next = cnt_next < CW1'(DEPTH);
    end

    // Fetch FSM next state, request address and PC update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_ld   = 1'b0;
        pc_d    = pc_inc;
        unique case (state_q)
            F_IDLE: begin
                if (redirect_i) begin
                    pc_ld = 1'b1;
                    pc_d  = tgt;
                end else if (space_next) begin
                    state_d = F_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            F_WAIT: begin
                if (redirect_i) begin
                    pc_ld   = 1'b1;
                    pc_d    = tgt;
                    state_d = bus.imem_resp_i ? F_IDLE : F_DROP;
                end else if (bus.imem_resp_i) begin
                    pc_ld = 1'b1;
                    if (space_next) begin
                        addr_d = pc_inc;
                    end else begin
                        state_d = F_IDLE;
                    end
                end
            end
            F_DROP: begin
                if (redirect_i) begin
                    pc_ld = 1'b1;
                    pc_d  = tgt;
                end
                if (bus.imem_resp_i) begin
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // FSM state and held request address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= F_IDLE;
            addr_q  <= RESET_VEC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.imem_read_o    = (state_q != F_IDLE);
    assign bus.imem_addr_o    = addr_q;
    assign bus.IF_valid_o     = fq_valid;
    assign bus.IF_pc_out_o    = XLEN'(head.pc);
    assign bus.IF_instr_out_o = head.instr;
    assign fq_count_o         = cnt;

    a_resp_state: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_resp_i |-> (state_q != F_IDLE));

    a_addr_align: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_read_o |-> (bus.imem_addr_o[1:0] == 2'b00));

    a_count_max: assert property (@(posedge clk) disable iff (!rst)
        {1'b0, cnt} <= CW1'(DEPTH));

endmodule
